alu_scan: RTL and testbench

ALU_SCAN -- requirements
Module: alu_scan

---
 rtl/alu_scan_pkg.sv | 21 ++
 rtl/alu_scan_core.sv | 54 +++++
 rtl/alu_scan.sv | 111 +++++++++++
 tb/tb_alu_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scan_pkg.sv
// Shared definitions for the alu_scan block: operation encoding and small helpers.
// Optional feature macro: ALU_SCAN_FLAGS_EN (adds carry/zero flag outputs and flops).
package alu_scan_pkg;

  // Width of the operation select field.
  localparam int unsigned OpWidth = 2;

  // Operation select encoding.
  typedef enum logic [OpWidth-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Arithmetic operations are the only ones that can produce a carry/borrow.
  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_scan_core.sv
// Combinational ALU datapath: next result (and, with ALU_SCAN_FLAGS_EN, carry and zero)
// from the operation select and the two operands. Holds no state.
module alu_scan_core
  import alu_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OpWidth-1:0] op_code_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef ALU_SCAN_FLAGS_EN
  output logic               carry_o,
  output logic               zero_o,
`endif
  output logic [WIDTH-1:0]   res_o
);

  op_e op;
  assign op = op_e'(op_code_i);

`ifdef ALU_SCAN_FLAGS_EN
  // One extra bit holds carry-out for ADD and borrow for SUB (set when a < b unsigned).
  logic [WIDTH:0] ext;

  // Extended-width operation result; the MSB is the carry/borrow.
  always_comb begin
    ext = '0;
    unique case (op)
      OP_ADD:  ext = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  ext = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  ext = {1'b0, a_i & b_i};
      OP_OR:   ext = {1'b0, a_i | b_i};
      default: ext = '0;
    endcase
  end

  assign res_o   = ext[WIDTH-1:0];
  assign carry_o = is_arith(op) & ext[WIDTH];
  assign zero_o  = (ext[WIDTH-1:0] == '0);
`else
  // Plain modulo-2^WIDTH operation result.
  always_comb begin
    res_o = '0;
    unique case (op)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_scan.sv
// Registered ALU with a serial scan chain through its result register.
// scan_en=0 captures the ALU output each edge; scan_en=1 shifts the chain by one bit.
// Optional feature macro: ALU_SCAN_FLAGS_EN adds carry/zero flag flops, which extend the
// chain as scan_in -> result[0..WIDTH-1] -> carry -> zero -> scan_out.
module alu_scan
  import alu_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OpWidth-1:0] op_code,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               scan_en,
  input  logic               scan_in,
`ifdef ALU_SCAN_FLAGS_EN
  output logic               carry,
  output logic               zero,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               scan_out
);

  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

`ifdef ALU_SCAN_FLAGS_EN
  logic core_carry;
  logic core_zero;
  logic carry_d;
  logic carry_q;
  logic zero_d;
  logic zero_q;

  alu_scan_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_code_i (op_code),
    .a_i       (A),
    .b_i       (B),
    .carry_o   (core_carry),
    .zero_o    (core_zero),
    .res_o     (core_res)
  );
`else
  alu_scan_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_code_i (op_code),
    .a_i       (A),
    .b_i       (B),
    .res_o     (core_res)
  );
`endif

  // Next-state mux for the result register: shift the chain or capture the ALU output.
  always_comb begin
    result_d = result_q;
    if (scan_en) begin
      result_d = {result_q[WIDTH-2:0], scan_in};
    end else begin
      result_d = core_res;
    end
  end

  // Result register; reset wins over both shift and capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef ALU_SCAN_FLAGS_EN
  // Flag next-state: in shift mode carry follows result MSB and zero follows carry.
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (scan_en) begin
      carry_d = result_q[WIDTH-1];
      zero_d  = carry_q;
    end else begin
      carry_d = core_carry;
      zero_d  = core_zero;
    end
  end

  // Flag registers, cleared together with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry    = carry_q;
  assign zero     = zero_q;
  assign scan_out = zero_q;
`else
  assign scan_out = result_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_alu_scan.sv
// Self-checking bench for alu_scan: directed table, hand sequences for scan/reset corners,
// and randomized traffic against a bit-list model of the scan chain.
module tb_alu_scan;

  localparam int W = 4;
`ifdef ALU_SCAN_FLAGS_EN
  localparam int NF = 2;
`else
  localparam int NF = 0;
`endif
  localparam int CL = W + NF;

  logic         clk;
  logic         rst;
  logic [1:0]   op_code;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         scan_en;
  logic         scan_in;
  logic [W-1:0] result;
  logic         scan_out;
`ifdef ALU_SCAN_FLAGS_EN
  logic         carry;
  logic         zero;
`endif

  alu_scan #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_code  (op_code),
    .A        (A),
    .B        (B),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
`ifdef ALU_SCAN_FLAGS_EN
    .carry    (carry),
    .zero     (zero),
`endif
    .result   (result),
    .scan_out (scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Model: chain bits listed from the scan_in end; [0..W-1] result, then carry, zero.
  logic m_chain [CL];

  function automatic void model_edge(input logic r, input logic se, input logic si,
                                     input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    int unsigned ua, ub, m, rv;
    logic c;
    ua = a;
    ub = b;
    m  = 1 << W;
    rv = 0;
    c  = 1'b0;
    if (r) begin
      for (int i = 0; i < CL; i++) m_chain[i] = 1'b0;
    end else if (se) begin
      for (int i = CL - 1; i > 0; i--) m_chain[i] = m_chain[i-1];
      m_chain[0] = si;
    end else begin
      case (op)
        2'd0: begin rv = (ua + ub) % m;     c = (ua + ub) >= m; end
        2'd1: begin rv = (ua + m - ub) % m; c = ua < ub;        end
        2'd2: begin rv = ua & ub;           c = 1'b0;           end
        default: begin rv = ua | ub;        c = 1'b0;           end
      endcase
      for (int i = 0; i < W; i++) m_chain[i] = rv[i];
`ifdef ALU_SCAN_FLAGS_EN
      m_chain[W]   = c;
      m_chain[W+1] = (rv == 0);
`endif
    end
  endfunction

  function automatic logic [W-1:0] m_result();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m_chain[i];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".result"}, 32'(result), 32'(m_result()));
    cmp({tag, ".scan_out"}, 32'(scan_out), 32'(m_chain[CL-1]));
`ifdef ALU_SCAN_FLAGS_EN
    cmp({tag, ".carry"}, 32'(carry), 32'(m_chain[W]));
    cmp({tag, ".zero"}, 32'(zero), 32'(m_chain[W+1]));
`endif
  endtask

  // Drive inputs, let one rising edge happen, update the model, return at the falling edge.
  task automatic step(input logic r, input logic se, input logic si, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    rst     = r;
    scan_en = se;
    scan_in = si;
    op_code = op;
    A       = a;
    B       = b;
    @(posedge clk);
    model_edge(r, se, si, op, a, b);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_seq;
    n_vec  = 0;
    n_miss = 0;

    vecs[0] = '{2'b00, 4'h3, 4'h5, 4'h8, 1'b0};
    vecs[1] = '{2'b01, 4'h8, 4'h3, 4'h5, 1'b0};
    vecs[2] = '{2'b10, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[3] = '{2'b11, 4'h5, 4'h3, 4'h7, 1'b0};
    vecs[4] = '{2'b00, 4'hF, 4'h1, 4'h0, 1'b1};
    vecs[5] = '{2'b01, 4'h0, 4'h1, 4'hF, 1'b1};
    vecs[6] = '{2'b00, 4'h7, 4'h7, 4'hE, 1'b0};
    vecs[7] = '{2'b01, 4'h5, 4'h5, 4'h0, 1'b0};
    vecs[8] = '{2'b11, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[9] = '{2'b10, 4'hF, 4'h6, 4'h6, 1'b0};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    rst = 1'b0;
    cmp("reset.result", 32'(result), 32'h0);
    cmp("reset.scan_out", 32'(scan_out), 32'h0);
    check_model("reset");

    // Functional capture table.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      cmp($sformatf("tbl%0d.result", i), 32'(result), 32'(vecs[i].res));
`ifdef ALU_SCAN_FLAGS_EN
      cmp($sformatf("tbl%0d.carry", i), 32'(carry), 32'(vecs[i].c));
      cmp($sformatf("tbl%0d.zero", i), 32'(zero), 32'(vecs[i].res == 0));
`endif
      check_model($sformatf("tbl%0d", i));
    end

    // Shift 1,0,1,1 in after reset.
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 4'hF, 4'hF);
    step(1'b0, 1'b1, 1'b0, 2'b01, 4'hF, 4'hF);
    step(1'b0, 1'b1, 1'b1, 2'b10, 4'hF, 4'hF);
    step(1'b0, 1'b1, 1'b1, 2'b11, 4'hF, 4'hF);
    cmp("shift1011.result", 32'(result), 32'hB);
`ifdef ALU_SCAN_FLAGS_EN
    cmp("shift1011.scan_out", 32'(scan_out), 32'h0);
`else
    cmp("shift1011.scan_out", 32'(scan_out), 32'h1);
`endif
    check_model("shift1011");

    // Mid-shift reset with scan_en held high.
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0);
    cmp("midrst.pre", 32'(result), 32'h3);
    step(1'b1, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0);
    cmp("midrst.result", 32'(result), 32'h0);
    cmp("midrst.scan_out", 32'(scan_out), 32'h0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0);
    cmp("midrst.resume", 32'(result), 32'h1);
    check_model("midrst");

    // Capture ADD 3+5, then unload with scan_in=0; scan_out observed before each edge.
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'h3, 4'h5);
`ifdef ALU_SCAN_FLAGS_EN
    exp_seq = 4'b0100;
`else
    exp_seq = 4'b0001;
`endif
    for (int i = 0; i < 4; i++) begin
      cmp($sformatf("unload%0d.scan_out", i), 32'(scan_out), 32'(exp_seq[i]));
      step(1'b0, 1'b1, 1'b0, 2'b01, 4'h9, 4'h2);
    end
    check_model("unload");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
